// File: rtl/tdm_channel_link_if.sv
// Bundle of channel-side and sink-side signals for tdm_channel_link.
// Combinational bundle only; it adds no latency.
// No backpressure: the link takes a word whenever en is high.
//
// Signals:
//   iData  : parallel channel inputs; channel k is iData[k*WIDTH +: WIDTH]
//   en     : transfer enable
//   mode   : 0 = manual (sel), 1 = auto-scan (internal pointer)
//   sel    : manual channel address
//   oData  : demultiplexed output slices
//   oValid : one-hot per-channel write strobe
//   cur_ch : scan pointer (next channel sampled in auto-scan)
//   oErr   : pulse flagging an out-of-range manual address
// Modports:
//   master : the source/sink side that drives the inputs and observes the outputs
//   slave  : the link itself
interface tdm_channel_link_if #(
    parameter int CH    = 8,
    parameter int WIDTH = 1
);
    localparam int SELW = $clog2(CH);

    logic [CH*WIDTH-1:0] iData;
    logic                en;
    logic                mode;
    logic [SELW-1:0]     sel;
    logic [CH*WIDTH-1:0] oData;
    logic [CH-1:0]       oValid;
    logic [SELW-1:0]     cur_ch;
    logic                oErr;

    modport master (
        output iData,
        output en,
        output mode,
        output sel,
        input  oData,
        input  oValid,
        input  cur_ch,
        input  oErr
    );

    modport slave (
        input  iData,
        input  en,
        input  mode,
        input  sel,
        output oData,
        output oValid,
        output cur_ch,
        output oErr
    );
endinterface

// File: rtl/tdm_channel_link.sv
// N-channel time-multiplexed link: one channel per cycle onto a registered bus, then demuxed to its slice.
// Latency: 2 cycles (input sampled at edge N shows on oData/oValid after edge N+1).
// No backpressure: every enabled cycle moves one word; en=0 inserts a bubble.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   lnk  : tdm_channel_link_if slave modport (iData, en, mode, sel in; oData, oValid, cur_ch, oErr out)
//
// Parameters:
//   CH    : number of channels (>= 2, any value)
//   WIDTH : bits per channel
//   IDLE  : idle bit level; an idle slice is WIDTH copies of bit 0 of IDLE
//   HOLD  : 0 = non-addressed slices return to idle, 1 = they keep their last value
module tdm_channel_link #(
    parameter int CH    = 8,
    parameter int WIDTH = 1,
    parameter int IDLE  = 1,
    parameter bit HOLD  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    tdm_channel_link_if.slave  lnk
);
    localparam int                  SELW     = $clog2(CH);
    localparam logic                IDLE_B   = ((IDLE % 2) != 0);
    localparam logic [SELW-1:0]     LAST_CH  = SELW'(CH - 1);
    localparam logic [CH*WIDTH-1:0] IDLE_BUS = {(CH*WIDTH){IDLE_B}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SELW-1:0]     ptr_q,     ptr_d;
    logic                bus_v_q,   bus_v_d;
    logic                bus_err_q, bus_err_d;
    logic [SELW-1:0]     bus_ch_q,  bus_ch_d;
    logic [WIDTH-1:0]    bus_dat_q, bus_dat_d;
    logic [CH*WIDTH-1:0] odat_q,    odat_d;
    logic [CH-1:0]       ovld_q,    ovld_d;
    logic                oerr_q,    oerr_d;

    // ------------------------------------------------------------------
    // Stage 1: channel selection and capture onto the shared bus
    // ------------------------------------------------------------------
    logic [SELW-1:0]  addr;
    logic             addr_ok;
    logic [WIDTH-1:0] addr_dat;

    always_comb begin
        addr     = lnk.mode ? ptr_q : lnk.sel;
        // With non-power-of-two CH the address field can encode values past the
        // last channel; only manual mode can produce them since ptr_q wraps early.
        addr_ok  = (int'(addr) < CH);

        // Explicit mux rather than a variable part-select so an out-of-range
        // address never indexes past iData.
        addr_dat = '0;
        for (int i = 0; i < CH; i++) begin
            if (int'(addr) == i) begin
                addr_dat = lnk.iData[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        bus_v_d   = lnk.en && addr_ok;
        bus_err_d = lnk.en && !lnk.mode && !addr_ok;
        bus_ch_d  = bus_ch_q;
        bus_dat_d = bus_dat_q;
        if (bus_v_d) begin
            bus_ch_d  = addr;
            bus_dat_d = addr_dat;
        end

        // The pointer only moves on enabled auto-scan cycles; manual mode
        // freezes it so auto-scan resumes where it left off.
        ptr_d = ptr_q;
        if (lnk.en && lnk.mode) begin
            ptr_d = (ptr_q == LAST_CH) ? '0 : ptr_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: demultiplex the bus word into its output slice
    // ------------------------------------------------------------------
    always_comb begin
        odat_d = HOLD ? odat_q : IDLE_BUS;
        ovld_d = '0;
        for (int i = 0; i < CH; i++) begin
            if (bus_v_q && (int'(bus_ch_q) == i)) begin
                odat_d[i*WIDTH +: WIDTH] = bus_dat_q;
                ovld_d[i]                = 1'b1;
            end
        end
        // The error travels down the bus stage alongside the (absent) word, so
        // it lands in a cycle whose oValid is necessarily zero.
        oerr_d = bus_err_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            bus_v_q   <= 1'b0;
            bus_err_q <= 1'b0;
            bus_ch_q  <= '0;
            bus_dat_q <= '0;
            odat_q    <= IDLE_BUS;
            ovld_q    <= '0;
            oerr_q    <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            bus_v_q   <= bus_v_d;
            bus_err_q <= bus_err_d;
            bus_ch_q  <= bus_ch_d;
            bus_dat_q <= bus_dat_d;
            odat_q    <= odat_d;
            ovld_q    <= ovld_d;
            oerr_q    <= oerr_d;
        end
    end

    assign lnk.oData  = odat_q;
    assign lnk.oValid = ovld_q;
    assign lnk.cur_ch = ptr_q;
    assign lnk.oErr   = oerr_q;

endmodule
